typed_mem_responder: RTL and testbench

//   Responder end of the typed request/response interface driven by our initiator blocks.

---
 rtl/typed_mem_responder.sv | 107 ++++++++++
 tb/tb_typed_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typed_mem_responder.sv
// typed_mem_responder
// Responder side of the typed request/response interface. It accepts one read or write
// at a time into a small register file. It answers with a single response after a fixed
// latency. The address and data widths come from type parameters.

module typed_mem_responder #(
    parameter int  DEPTH      = 8,
    parameter int  RD_LATENCY = 1,
    parameter type ADDR       = bit [31:0],
    parameter type DATA       = logic [7:0]
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  ADDR         req_addr,
    input  DATA         req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output DATA         rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = $bits(ADDR);
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [3:0]       lat_cnt;
    DATA              mem [DEPTH];

    logic [AW-1:0]    addr_bits;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             accept;

    // Treat the address as an unsigned bit vector, so that a signed ADDR such as longint
    // with a negative value counts as out of range. DEPTH is a power of two. That means
    // "addr < DEPTH" is the same as "every bit above the index field is zero".
    assign addr_bits = req_addr;
    assign idx       = addr_bits[IDX_W-1:0];
    assign in_range  = (addr_bits >> IDX_W) == '0;

    // Requests are only taken in IDLE. Holding reset high forces ready low.
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Main FSM: accept, count out the latency, present the response, and track completions
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                        rsp_err <= !in_range;
                        if (req_write) begin
                            rsp_rdata <= '0;
                            if (in_range) begin
                                mem[idx] <= req_wdata;
                            end
                        end else begin
                            rsp_rdata <= in_range ? mem[idx] : '0;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_typed_mem_responder.sv
// tb_typed_mem_responder
// Directed bench for two instances of typed_mem_responder:
//   dut_a: 8-bit 4-state data, 32-bit address, latency 2.
//   dut_b: shortint data, longint address, latency 1.

module tb_typed_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    bit   [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] txn_count;

    logic        b_req_valid;
    logic        b_req_ready;
    logic        b_req_write;
    longint      b_req_addr;
    shortint     b_req_wdata;
    logic        b_rsp_valid;
    logic        b_rsp_ready;
    shortint     b_rsp_rdata;
    logic        b_rsp_err;
    logic [15:0] b_txn_count;

    typed_mem_responder #(
        .DEPTH(8), .RD_LATENCY(2), .ADDR(bit [31:0]), .DATA(logic [7:0])
    ) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .txn_count(txn_count)
    );

    typed_mem_responder #(
        .DEPTH(8), .RD_LATENCY(1), .ADDR(longint), .DATA(shortint)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .txn_count(b_txn_count)
    );

    typedef struct {
        logic        write;
        bit   [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;

    int errors    = 0;
    int checks    = 0;
    int exp_txn   = 0;
    int exp_txn_b = 0;
    int accept_cnt = 0;

    // Count the accept handshakes seen on dut_a, for the back-pressure sequence
    always @(posedge clk) begin
        if (rst === 1'b0 && req_valid === 1'b1 && req_ready === 1'b1) accept_cnt++;
    end

    // Global time limit so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Run one full transaction on dut_a and check latency, data, error flag and count
    task automatic applyStimulus(input vec_t v, input string tag);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'bx;
        req_wdata = 'x;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'd2);
        checkOutput({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        checkOutput({tag, "_err"}, 64'(rsp_err), 64'(v.exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_txn++;
        checkOutput({tag, "_valid_drop"}, 64'(rsp_valid), 64'd0);
        checkOutput({tag, "_txn"}, 64'(txn_count), 64'(16'(exp_txn)));
    endtask

    // One transaction on dut_b, which has a latency of 1
    task automatic txnB(input logic write, input longint addr, input shortint wdata,
                        input shortint exp_rdata, input logic exp_err, input string tag);
        int n;
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_write = write;
        b_req_addr  = addr;
        b_req_wdata = wdata;
        n = 0;
        while (b_req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_ready"}, 64'(b_req_ready), 64'd1);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        n = 0;
        while (b_rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_latency"}, 64'(n), 64'd1);
        checkOutput({tag, "_rdata"}, 64'(b_rsp_rdata), 64'(exp_rdata));
        checkOutput({tag, "_err"}, 64'(b_rsp_err), 64'(exp_err));
        b_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        b_rsp_ready = 1'b0;
        exp_txn_b++;
        checkOutput({tag, "_txn"}, 64'(b_txn_count), 64'(16'(exp_txn_b)));
    endtask

    vec_t vecs [12];

    initial begin
        int   n;
        int   acc0;
        logic stable;
        logic seen;
        vec_t rv;

        // Expected values assume storage is all zero after reset
        vecs[0]  = '{1'b0, 32'd3,          8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 32'd5,          8'hA5, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 32'd5,          8'h00, 8'hA5, 1'b0};
        vecs[3]  = '{1'b0, 32'd8,          8'h00, 8'h00, 1'b1};
        vecs[4]  = '{1'b1, 32'hFFFF_FFFF,  8'h11, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 32'd0,          8'h3C, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 32'd7,          8'hC3, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 32'd0,          8'h00, 8'h3C, 1'b0};
        vecs[8]  = '{1'b0, 32'd7,          8'h00, 8'hC3, 1'b0};
        vecs[9]  = '{1'b0, 32'd5,          8'h00, 8'hA5, 1'b0};
        vecs[10] = '{1'b1, 32'd5,          8'h5A, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 32'd5,          8'h00, 8'h5A, 1'b0};

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        rsp_ready   = 1'b0;
        b_req_valid = 1'b0;
        b_req_write = 1'b0;
        b_req_addr  = 0;
        b_req_wdata = 0;
        b_rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("reset_rsp_err",   64'(rsp_err),   64'd0);
        checkOutput("reset_txn_count", 64'(txn_count), 64'd0);
        rst = 1'b0;

        // X on the request fields while req_valid is low must be harmless
        @(negedge clk);
        req_write = 1'bx;
        req_wdata = 'x;
        checkOutput("idle_req_ready", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Hold back-pressure: the response stays put and no second request gets in
        acc0 = accept_cnt;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'd0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_valid_up", 64'(rsp_valid), 64'd1);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 ||
                rsp_rdata !== 8'h3C || rsp_err !== 1'b0) stable = 1'b0;
        end
        checkOutput("hold_stable", 64'(stable), 64'd1);
        checkOutput("hold_one_accept", 64'(accept_cnt - acc0), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("hold_release_accept", 64'(accept_cnt - acc0), 64'd2);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("hold_second_rdata", 64'(rsp_rdata), 64'h3C);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_txn += 2;
        checkOutput("hold_txn", 64'(txn_count), 64'(16'(exp_txn)));

        // Reset during WAIT: the write already landed, but reset wipes it and drops the response
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'd2;
        req_wdata = 8'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_req_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_txn = 0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checkOutput("rst_no_rsp", 64'(seen), 64'd0);
        checkOutput("rst_txn_count", 64'(txn_count), 64'd0);
        for (int a = 0; a < 8; a++) begin
            rv = '{1'b0, 32'(a), 8'h00, 8'h00, 1'b0};
            applyStimulus(rv, $sformatf("clr%0d", a));
        end

        // Second instance: 2-state shortint data, longint address, single-cycle latency
        txnB(1'b1, 64'sd7, 16'sh7FFF, 16'sh0000, 1'b0, "b_wr7");
        txnB(1'b0, 64'sd7, 16'sh0000, 16'sh7FFF, 1'b0, "b_rd7");
        txnB(1'b0, -64'sd1, 16'sh0000, 16'sh0000, 1'b1, "b_rdneg");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
